// File: rtl/scaler_readout_if.sv
// rtl/scaler_readout_if.sv - read-side valid/ack handshake between scaler_readout and the register bank
interface scaler_readout_if;
  logic        RD_VALID;
  logic [31:0] RD_DELTA;
  logic [15:0] RD_SEQ;
  logic        RD_ACK;

  modport master (output RD_VALID, output RD_DELTA, output RD_SEQ, input RD_ACK);
  modport slave  (input RD_VALID, input RD_DELTA, input RD_SEQ, output RD_ACK);
endinterface

// File: rtl/scaler_readout.sv
// rtl/scaler_readout.sv - PPS-snapshot scaler readout with per-second delta FWFT FIFO
module scaler_readout #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLK120,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  PPS,
  input  logic [31:0]           COUNT,
  input  logic                  CLR_OVF,
  scaler_readout_if.master      rd,
  output logic [DEPTH_LOG2:0]   FILL,
  output logic                  OVERFLOW,
  output logic [7:0]            DROP_COUNT
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                state;
  logic                  s1, s2, s3;
  logic                  pps_edge;
  logic [31:0]           prev;
  logic [31:0]           delta;
  logic [15:0]           seq;
  logic [15:0]           seq_next;
  logic [31:0]           mem_delta [DEPTH];
  logic [15:0]           mem_seq   [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic                  push, pop, full, accept, drop;

  assign pps_edge = s2 & ~s3;
  assign delta    = COUNT - prev;
  assign seq_next = seq + 16'd1;
  // ENABLE low in the edge cycle suppresses the push as well as the state update
  assign push     = (state == RUN) && ENABLE && pps_edge;
  assign pop      = rd.RD_ACK && (FILL != '0);
  assign full     = (FILL == FILL_FULL);
  assign accept   = push && (!full || pop);
  assign drop     = push && full && !pop;

  assign rd.RD_VALID = (FILL != '0);
  assign rd.RD_DELTA = rd.RD_VALID ? mem_delta[rptr] : '0;
  assign rd.RD_SEQ   = rd.RD_VALID ? mem_seq[rptr]   : '0;

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= PPS;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state <= IDLE;
      prev  <= '0;
      seq   <= '0;
    end else if (!ENABLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  state <= PRIME;
        PRIME: if (pps_edge) begin
          prev  <= COUNT;
          state <= RUN;
        end
        RUN:   if (pps_edge) begin
          prev <= COUNT;
          seq  <= seq_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK120) begin
    if (accept) begin
      mem_delta[wptr] <= delta;
      mem_seq[wptr]   <= seq_next;
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
      FILL <= '0;
    end else begin
      if (accept) wptr <= wptr + PTR_ONE;
      if (pop)    rptr <= rptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   FILL <= FILL + FILL_ONE;
        2'b01:   FILL <= FILL - FILL_ONE;
        default: FILL <= FILL;
      endcase
    end
  end

  // a drop coinciding with CLR_OVF restarts the count at one rather than clearing it
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      if (CLR_OVF)                  DROP_COUNT <= 8'd1;
      else if (DROP_COUNT != 8'hFF) DROP_COUNT <= DROP_COUNT + 8'd1;
    end else if (CLR_OVF) begin
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end
  end
endmodule

// File: tb/tb_scaler_readout.sv
// tb/tb_scaler_readout.sv - directed self-checking bench for scaler_readout
module tb_scaler_readout;
  logic        CLK120 = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        PPS;
  logic [31:0] COUNT;
  logic        CLR_OVF;
  logic [2:0]  FILL;
  logic        OVERFLOW;
  logic [7:0]  DROP_COUNT;
  int          errors = 0;
  int          checks = 0;

  scaler_readout_if rd_if ();

  scaler_readout #(.DEPTH_LOG2(2)) dut (
    .CLK120     (CLK120),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .PPS        (PPS),
    .COUNT      (COUNT),
    .CLR_OVF    (CLR_OVF),
    .rd         (rd_if.master),
    .FILL       (FILL),
    .OVERFLOW   (OVERFLOW),
    .DROP_COUNT (DROP_COUNT)
  );

  always #4 CLK120 = ~CLK120;

  task automatic tick();
    @(posedge CLK120);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; ENABLE = 1'b0; PPS = 1'b0; COUNT = '0; CLR_OVF = 1'b0; rd_if.RD_ACK = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic start_run_prep();
    do_reset();
    ENABLE = 1'b1;
    tick();
  endtask

  task automatic pps_pulse(input logic [31:0] v, input int hi);
    COUNT = v;
    PPS = 1'b1;
    repeat (hi) tick();
    PPS = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop_one();
    rd_if.RD_ACK = 1'b1;
    tick();
    rd_if.RD_ACK = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_if.RD_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", rd_if.RD_VALID); end
    checks++; if (rd_if.RD_DELTA !== 32'd0) begin errors++; $display("FAIL rst_delta: got %0h expected 0", rd_if.RD_DELTA); end
    checks++; if (rd_if.RD_SEQ !== 16'd0) begin errors++; $display("FAIL rst_seq: got %0d expected 0", rd_if.RD_SEQ); end
    checks++; if (FILL !== 3'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", FILL); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", OVERFLOW); end
    checks++; if (DROP_COUNT !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", DROP_COUNT); end
  endtask

  task automatic test_basic_delta();
    start_run_prep();
    pps_pulse(32'd100, 3);
    checks++; if (FILL !== 3'd0) begin errors++; $display("FAIL basic_prime_fill: got %0d expected 0", FILL); end
    COUNT = 32'd350;
    PPS = 1'b1;
    tick();
    checks++; if (rd_if.RD_VALID !== 1'b0) begin errors++; $display("FAIL basic_lat1: got %0b expected 0", rd_if.RD_VALID); end
    tick();
    checks++; if (rd_if.RD_VALID !== 1'b0) begin errors++; $display("FAIL basic_lat2: got %0b expected 0", rd_if.RD_VALID); end
    tick();
    checks++; if (rd_if.RD_VALID !== 1'b1) begin errors++; $display("FAIL basic_lat3: got %0b expected 1", rd_if.RD_VALID); end
    checks++; if (rd_if.RD_DELTA !== 32'd250) begin errors++; $display("FAIL basic_delta: got %0d expected 250", rd_if.RD_DELTA); end
    checks++; if (rd_if.RD_SEQ !== 16'd1) begin errors++; $display("FAIL basic_seq: got %0d expected 1", rd_if.RD_SEQ); end
    PPS = 1'b0;
    repeat (3) tick();
    checks++; if (FILL !== 3'd1) begin errors++; $display("FAIL basic_fill: got %0d expected 1", FILL); end
    pop_one();
    checks++; if (FILL !== 3'd0) begin errors++; $display("FAIL basic_pop_fill: got %0d expected 0", FILL); end
  endtask

  task automatic test_wrap();
    start_run_prep();
    pps_pulse(32'hFFFF_FFF0, 3);
    pps_pulse(32'h0000_0010, 3);
    checks++; if (rd_if.RD_DELTA !== 32'h20) begin errors++; $display("FAIL wrap_delta: got %0h expected 20", rd_if.RD_DELTA); end
    checks++; if (rd_if.RD_SEQ !== 16'd1) begin errors++; $display("FAIL wrap_seq: got %0d expected 1", rd_if.RD_SEQ); end
    pop_one();
  endtask

  task automatic test_overflow();
    start_run_prep();
    pps_pulse(32'd1000, 3);
    for (int i = 1; i <= 6; i++) pps_pulse(32'd1000 + 32'(i) * 32'd100, 3);
    checks++; if (FILL !== 3'd4) begin errors++; $display("FAIL ovf_fill: got %0d expected 4", FILL); end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", OVERFLOW); end
    checks++; if (DROP_COUNT !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", DROP_COUNT); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rd_if.RD_SEQ !== 16'(i)) begin errors++; $display("FAIL ovf_read_seq%0d: got %0d expected %0d", i, rd_if.RD_SEQ, i); end
      checks++; if (rd_if.RD_DELTA !== 32'd100) begin errors++; $display("FAIL ovf_read_delta%0d: got %0d expected 100", i, rd_if.RD_DELTA); end
      pop_one();
    end
    checks++; if (rd_if.RD_VALID !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b expected 0", rd_if.RD_VALID); end
    pps_pulse(32'd1700, 3);
    checks++; if (rd_if.RD_SEQ !== 16'd7) begin errors++; $display("FAIL ovf_next_seq: got %0d expected 7", rd_if.RD_SEQ); end
    checks++; if (rd_if.RD_DELTA !== 32'd100) begin errors++; $display("FAIL ovf_next_delta: got %0d expected 100", rd_if.RD_DELTA); end
    pop_one();
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clr_flag: got %0b expected 0", OVERFLOW); end
    checks++; if (DROP_COUNT !== 8'd0) begin errors++; $display("FAIL ovf_clr_drop: got %0d expected 0", DROP_COUNT); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) pps_pulse(32'd1700 + 32'(i) * 32'd100, 3);
    checks++; if (FILL !== 3'd4) begin errors++; $display("FAIL fpp_prefill: got %0d expected 4", FILL); end
    COUNT = 32'd2200;
    PPS = 1'b1;
    repeat (2) tick();
    rd_if.RD_ACK = 1'b1;
    tick();
    rd_if.RD_ACK = 1'b0;
    PPS = 1'b0;
    checks++; if (FILL !== 3'd4) begin errors++; $display("FAIL fpp_fill: got %0d expected 4", FILL); end
    checks++; if (DROP_COUNT !== 8'd0) begin errors++; $display("FAIL fpp_drop: got %0d expected 0", DROP_COUNT); end
    checks++; if (rd_if.RD_SEQ !== 16'd9) begin errors++; $display("FAIL fpp_head_seq: got %0d expected 9", rd_if.RD_SEQ); end
    repeat (3) tick();
    pps_pulse(32'd2300, 3);
    checks++; if (DROP_COUNT !== 8'd1) begin errors++; $display("FAIL fpp_drop1: got %0d expected 1", DROP_COUNT); end
    COUNT = 32'd2400;
    PPS = 1'b1;
    repeat (2) tick();
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    PPS = 1'b0;
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL clr_drop_flag: got %0b expected 1", OVERFLOW); end
    checks++; if (DROP_COUNT !== 8'd1) begin errors++; $display("FAIL clr_drop_count: got %0d expected 1", DROP_COUNT); end
    repeat (3) tick();
    rd_if.RD_ACK = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      checks++; if (rd_if.RD_SEQ !== 16'(i)) begin errors++; $display("FAIL b2b_seq%0d: got %0d expected %0d", i, rd_if.RD_SEQ, i); end
      tick();
    end
    rd_if.RD_ACK = 1'b0;
    checks++; if (FILL !== 3'd0) begin errors++; $display("FAIL b2b_fill: got %0d expected 0", FILL); end
  endtask

  task automatic test_long_pps();
    start_run_prep();
    pps_pulse(32'd0, 3);
    pps_pulse(32'd5000, 1000);
    checks++; if (FILL !== 3'd1) begin errors++; $display("FAIL long_fill: got %0d expected 1", FILL); end
    checks++; if (rd_if.RD_DELTA !== 32'd5000) begin errors++; $display("FAIL long_delta: got %0d expected 5000", rd_if.RD_DELTA); end
    pop_one();
    rd_if.RD_ACK = 1'b1;
    repeat (3) tick();
    rd_if.RD_ACK = 1'b0;
    checks++; if (FILL !== 3'd0) begin errors++; $display("FAIL empty_ack_fill: got %0d expected 0", FILL); end
    pps_pulse(32'd5100, 3);
    checks++; if (rd_if.RD_SEQ !== 16'd2) begin errors++; $display("FAIL empty_ack_seq: got %0d expected 2", rd_if.RD_SEQ); end
    checks++; if (rd_if.RD_DELTA !== 32'd100) begin errors++; $display("FAIL empty_ack_delta: got %0d expected 100", rd_if.RD_DELTA); end
  endtask

  task automatic test_reset_reenable();
    start_run_prep();
    pps_pulse(32'd0, 3);
    pps_pulse(32'd10, 3);
    pps_pulse(32'd30, 3);
    pps_pulse(32'd60, 3);
    checks++; if (FILL !== 3'd3) begin errors++; $display("FAIL rr_prefill: got %0d expected 3", FILL); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++; if (rd_if.RD_VALID !== 1'b0) begin errors++; $display("FAIL rr_valid: got %0b expected 0", rd_if.RD_VALID); end
    checks++; if (FILL !== 3'd0) begin errors++; $display("FAIL rr_fill: got %0d expected 0", FILL); end
    tick();
    pps_pulse(32'd100, 3);
    pps_pulse(32'd150, 3);
    checks++; if (rd_if.RD_SEQ !== 16'd1) begin errors++; $display("FAIL rr_seq1: got %0d expected 1", rd_if.RD_SEQ); end
    checks++; if (rd_if.RD_DELTA !== 32'd50) begin errors++; $display("FAIL rr_delta1: got %0d expected 50", rd_if.RD_DELTA); end
    ENABLE = 1'b0;
    repeat (2) tick();
    ENABLE = 1'b1;
    tick();
    pps_pulse(32'd400, 3);
    checks++; if (FILL !== 3'd1) begin errors++; $display("FAIL rr_prime_only: got %0d expected 1", FILL); end
    pps_pulse(32'd480, 3);
    checks++; if (FILL !== 3'd2) begin errors++; $display("FAIL rr_fill2: got %0d expected 2", FILL); end
    pop_one();
    checks++; if (rd_if.RD_SEQ !== 16'd2) begin errors++; $display("FAIL rr_seq2: got %0d expected 2", rd_if.RD_SEQ); end
    checks++; if (rd_if.RD_DELTA !== 32'd80) begin errors++; $display("FAIL rr_delta2: got %0d expected 80", rd_if.RD_DELTA); end
  endtask

  initial begin
    test_reset();
    test_basic_delta();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_long_pps();
    test_reset_reenable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
